// File: rtl/soc_reset_sequencer.sv
// Staged per-domain reset sequencer: hold all domains, release them in ascending order, then run.
// Optional watchdog re-sequencing is compiled in with `define RST_SEQ_WDT_EN.
module soc_reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int WDT_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sw_reset_req,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   all_ready,
  output logic [1:0]             reset_cause,
  output logic [1:0]             seq_state
);

  localparam int CNT_MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_MAX    = (CNT_MAX_HG > WDT_TIMEOUT) ? CNT_MAX_HG : WDT_TIMEOUT;
  localparam int CW         = $clog2(CNT_MAX + 1);
  localparam int IW         = $clog2(NUM_DOMAINS + 1);

  localparam logic [CW-1:0] HOLD_TGT = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_TGT  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_DONE = IW'(NUM_DOMAINS);

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  generate
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
        WDT_TIMEOUT < 1) begin : g_bad_params
      $error("soc_reset_sequencer: illegal parameter value");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_HOLD    = 2'b01,
    ST_RELEASE = 2'b10,
    ST_RUN     = 2'b11
  } state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic [IW-1:0]            idx, idx_nxt;
  logic [NUM_DOMAINS-1:0]   dom_nxt;
  logic [1:0]               cause_nxt;
  logic                     resync;
  logic [1:0]               resync_cause;

`ifdef RST_SEQ_WDT_EN
  localparam logic [CW-1:0] WDT_TGT = CW'(WDT_TIMEOUT - 1);
  logic [CW-1:0] wdt, wdt_nxt;
  logic          wdt_to;

  // Kick has priority over expiry; counter only runs while in RUN.
  always_comb begin
    wdt_nxt = '0;
    wdt_to  = 1'b0;
    if (state == ST_RUN) begin
      if (wdt_kick)            wdt_nxt = '0;
      else if (wdt == WDT_TGT) wdt_to  = 1'b1;
      else                     wdt_nxt = wdt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdt <= '0;
    else if (resync) wdt <= '0;
    else wdt <= wdt_nxt;
  end

  assign resync       = (state != ST_ASSERT) && (sw_reset_req || wdt_to);
  assign resync_cause = sw_reset_req ? CAUSE_SW : CAUSE_WDT;
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
  assign resync          = (state != ST_ASSERT) && sw_reset_req;
  assign resync_cause    = CAUSE_SW;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    dom_nxt   = domain_reset_n;
    cause_nxt = reset_cause;
    case (state)
      ST_ASSERT: begin
        state_nxt = ST_HOLD;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        dom_nxt   = '0;
        if (sw_reset_req) cause_nxt = CAUSE_SW;
      end
      ST_HOLD: begin
        if (cnt == HOLD_TGT) begin
          state_nxt  = ST_RELEASE;
          cnt_nxt    = '0;
          dom_nxt[0] = 1'b1;
          idx_nxt    = IW'(1);
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        // idx is the next domain to release; reaching NUM_DOMAINS means all are out.
        if (idx == IDX_DONE) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else if (cnt == GAP_TGT) begin
          for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
            if (idx == IW'(k)) dom_nxt[k] = 1'b1;
          end
          idx_nxt = idx + 1'b1;
          cnt_nxt = '0;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
      end
      default: state_nxt = ST_ASSERT;
    endcase
    if (resync) begin
      state_nxt = ST_ASSERT;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      dom_nxt   = '0;
      cause_nxt = resync_cause;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_ASSERT;
      cnt            <= '0;
      idx            <= '0;
      domain_reset_n <= '0;
      reset_cause    <= CAUSE_POR;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      idx            <= idx_nxt;
      domain_reset_n <= dom_nxt;
      reset_cause    <= cause_nxt;
    end
  end

  assign all_ready = (state == ST_RUN);
  assign seq_state = state;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Directed bench for soc_reset_sequencer: default, minimal-parameter and short-watchdog instances.
`timescale 1ns/1ps
module tb_soc_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d = 1'b1, sw_d = 1'b0, kick_d = 1'b0;
  logic [3:0] dom_d;
  logic       rdy_d;
  logic [1:0] cause_d, st_d;

  logic       rst_m = 1'b1, sw_m = 1'b0, kick_m = 1'b0;
  logic [0:0] dom_m;
  logic       rdy_m;
  logic [1:0] cause_m, st_m;

  logic       rst_w = 1'b1, sw_w = 1'b0, kick_w = 1'b0;
  logic [3:0] dom_w;
  logic       rdy_w;
  logic [1:0] cause_w, st_w;

  int n_checks = 0;
  int n_fail   = 0;

  soc_reset_sequencer u_dut (
    .clk(clk), .reset(rst_d), .sw_reset_req(sw_d), .wdt_kick(kick_d),
    .domain_reset_n(dom_d), .all_ready(rdy_d), .reset_cause(cause_d), .seq_state(st_d)
  );

  soc_reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(1)) u_min (
    .clk(clk), .reset(rst_m), .sw_reset_req(sw_m), .wdt_kick(kick_m),
    .domain_reset_n(dom_m), .all_ready(rdy_m), .reset_cause(cause_m), .seq_state(st_m)
  );

  soc_reset_sequencer #(.WDT_TIMEOUT(32)) u_wdt (
    .clk(clk), .reset(rst_w), .sw_reset_req(sw_w), .wdt_kick(kick_w),
    .domain_reset_n(dom_w), .all_ready(rdy_w), .reset_cause(cause_w), .seq_state(st_w)
  );

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dom_d !== 4'b0000) begin n_fail++; $display("FAIL reset_dom got %b want 0000", dom_d); end
    n_checks++; if (rdy_d !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", rdy_d); end
    n_checks++; if (cause_d !== 2'b01) begin n_fail++; $display("FAIL reset_cause got %b want 01", cause_d); end
    n_checks++; if (st_d !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", st_d); end
    n_checks++; if (dom_m !== 1'b0) begin n_fail++; $display("FAIL reset_min_dom got %b want 0", dom_m); end
  endtask

  // Edge e counts from T0 (e=0); domain k high from e=17+8k, RUN from e=42.
  task automatic test_power_on();
    logic [3:0] exp_dom;
    logic [1:0] exp_st;
    @(negedge clk) rst_d = 1'b0;
    for (int e = 0; e <= 45; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) exp_dom[k] = (e >= 17 + 8 * k);
      exp_st = (e < 17) ? 2'b01 : (e < 42) ? 2'b10 : 2'b11;
      n_checks++; if (dom_d !== exp_dom) begin n_fail++; $display("FAIL por_dom e=%0d got %b want %b", e, dom_d, exp_dom); end
      n_checks++; if (rdy_d !== (e >= 42)) begin n_fail++; $display("FAIL por_rdy e=%0d got %b want %b", e, rdy_d, (e >= 42)); end
      n_checks++; if (st_d !== exp_st) begin n_fail++; $display("FAIL por_state e=%0d got %b want %b", e, st_d, exp_st); end
    end
    n_checks++; if (cause_d !== 2'b01) begin n_fail++; $display("FAIL por_cause got %b want 01", cause_d); end
  endtask

  task automatic test_sw_request();
    logic [3:0] exp_dom;
    repeat (14) @(posedge clk);
    #1 sw_d = 1'b1;
    @(posedge clk); #1;
    sw_d = 1'b0;
    n_checks++; if (dom_d !== 4'b0000) begin n_fail++; $display("FAIL sw_dom got %b want 0000", dom_d); end
    n_checks++; if (rdy_d !== 1'b0) begin n_fail++; $display("FAIL sw_rdy got %b want 0", rdy_d); end
    n_checks++; if (cause_d !== 2'b10) begin n_fail++; $display("FAIL sw_cause got %b want 10", cause_d); end
    n_checks++; if (st_d !== 2'b00) begin n_fail++; $display("FAIL sw_state got %b want 00", st_d); end
    for (int j = 1; j <= 43; j++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) exp_dom[k] = (j - 1 >= 17 + 8 * k);
      n_checks++; if (dom_d !== exp_dom) begin n_fail++; $display("FAIL sw_reseq_dom j=%0d got %b want %b", j, dom_d, exp_dom); end
      n_checks++; if (rdy_d !== (j >= 43)) begin n_fail++; $display("FAIL sw_reseq_rdy j=%0d got %b want %b", j, rdy_d, (j >= 43)); end
    end
  endtask

  task automatic test_reset_mid_release();
    @(negedge clk) rst_d = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_d = 1'b0;
    for (int e = 0; e <= 30; e++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (dom_d !== 4'b0011) begin n_fail++; $display("FAIL mid_pre_dom got %b want 0011", dom_d); end
    #2 rst_d = 1'b1;
    #1;
    n_checks++; if (dom_d !== 4'b0000) begin n_fail++; $display("FAIL mid_async_dom got %b want 0000", dom_d); end
    n_checks++; if (cause_d !== 2'b01) begin n_fail++; $display("FAIL mid_async_cause got %b want 01", cause_d); end
    n_checks++; if (st_d !== 2'b00) begin n_fail++; $display("FAIL mid_async_state got %b want 00", st_d); end
    // Request arrives while in ASSERT: cause changes, timing must not.
    @(negedge clk) begin rst_d = 1'b0; sw_d = 1'b1; end
    for (int e = 0; e <= 17; e++) begin
      @(posedge clk); #1;
      if (e == 0) begin
        sw_d = 1'b0;
        n_checks++; if (st_d !== 2'b01) begin n_fail++; $display("FAIL assert_sw_state got %b want 01", st_d); end
        n_checks++; if (cause_d !== 2'b10) begin n_fail++; $display("FAIL assert_sw_cause got %b want 10", cause_d); end
      end
      if (e == 16) begin
        n_checks++; if (dom_d !== 4'b0000) begin n_fail++; $display("FAIL restart_dom16 got %b want 0000", dom_d); end
      end
      if (e == 17) begin
        n_checks++; if (dom_d !== 4'b0001) begin n_fail++; $display("FAIL restart_dom17 got %b want 0001", dom_d); end
      end
    end
  endtask

  task automatic test_min_params();
    @(negedge clk) rst_m = 1'b0;
    for (int e = 0; e <= 3; e++) begin
      @(posedge clk); #1;
      n_checks++; if (dom_m !== (e >= 2)) begin n_fail++; $display("FAIL min_dom e=%0d got %b want %b", e, dom_m, (e >= 2)); end
      n_checks++; if (rdy_m !== (e >= 3)) begin n_fail++; $display("FAIL min_rdy e=%0d got %b want %b", e, rdy_m, (e >= 3)); end
    end
  endtask

  task automatic test_watchdog_timeout();
    @(negedge clk) rst_w = 1'b0;
    for (int e = 0; e <= 117; e++) begin
      @(posedge clk); #1;
      if (e == 42 || e == 73) begin
        n_checks++; if (rdy_w !== 1'b1) begin n_fail++; $display("FAIL wdt_run_rdy e=%0d got %b want 1", e, rdy_w); end
      end
      if (e == 74) begin
`ifdef RST_SEQ_WDT_EN
        n_checks++; if (st_w !== 2'b00) begin n_fail++; $display("FAIL wdt_to_state got %b want 00", st_w); end
        n_checks++; if (cause_w !== 2'b11) begin n_fail++; $display("FAIL wdt_to_cause got %b want 11", cause_w); end
        n_checks++; if (dom_w !== 4'b0000) begin n_fail++; $display("FAIL wdt_to_dom got %b want 0000", dom_w); end
`else
        n_checks++; if (st_w !== 2'b11) begin n_fail++; $display("FAIL nowdt_state got %b want 11", st_w); end
        n_checks++; if (cause_w !== 2'b01) begin n_fail++; $display("FAIL nowdt_cause got %b want 01", cause_w); end
`endif
      end
      if (e == 117) begin
        n_checks++; if (rdy_w !== 1'b1) begin n_fail++; $display("FAIL wdt_back_rdy got %b want 1", rdy_w); end
        n_checks++; if (dom_w !== 4'b1111) begin n_fail++; $display("FAIL wdt_back_dom got %b want 1111", dom_w); end
      end
    end
  endtask

  task automatic test_watchdog_kick();
    for (int i = 1; i <= 500; i++) begin
      @(posedge clk); #1;
      kick_w = 1'b0;
      n_checks++; if (rdy_w !== 1'b1) begin n_fail++; $display("FAIL kick_rdy i=%0d got %b want 1", i, rdy_w); end
      if (i % 20 == 0) kick_w = 1'b1;
    end
    @(posedge clk); #1;
    kick_w = 1'b0;
  endtask

  // Follows the last kick: sw request lands on the edge the watchdog would expire.
  task automatic test_sw_on_timeout();
    repeat (31) @(posedge clk);
    #1;
    n_checks++; if (st_w !== 2'b11) begin n_fail++; $display("FAIL pre_to_state got %b want 11", st_w); end
    sw_w = 1'b1;
    @(posedge clk); #1;
    sw_w = 1'b0;
    n_checks++; if (st_w !== 2'b00) begin n_fail++; $display("FAIL swto_state got %b want 00", st_w); end
    n_checks++; if (cause_w !== 2'b10) begin n_fail++; $display("FAIL swto_cause got %b want 10", cause_w); end
    n_checks++; if (dom_w !== 4'b0000) begin n_fail++; $display("FAIL swto_dom got %b want 0000", dom_w); end
    @(posedge clk); #1;
    n_checks++; if (st_w !== 2'b01) begin n_fail++; $display("FAIL swto_hold got %b want 01", st_w); end
    repeat (42) @(posedge clk);
    #1;
    n_checks++; if (rdy_w !== 1'b1) begin n_fail++; $display("FAIL swto_rdy got %b want 1", rdy_w); end
    n_checks++; if (dom_w !== 4'b1111) begin n_fail++; $display("FAIL swto_dom_end got %b want 1111", dom_w); end
    n_checks++; if (cause_w !== 2'b10) begin n_fail++; $display("FAIL swto_cause_end got %b want 10", cause_w); end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_request();
    test_reset_mid_release();
    test_min_params();
    test_watchdog_timeout();
    test_watchdog_kick();
    test_sw_on_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
